// File: rtl/except_sched.sv
// Exception/interrupt scheduler: arbitrates slot exceptions and interrupts, drives CP0 commit,
// pipeline flush and PC redirect. Optional event counter enabled by EXCEPT_SCHED_PERF_EN.
module except_sched #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_stall_i,
   input  logic        s0_valid_i,
   input  logic        s1_valid_i,
   input  logic [31:0] s0_pc_i,
   input  logic [31:0] s1_pc_i,
   input  logic        s0_ds_i,
   input  logic        s1_ds_i,
   input  logic [7:0]  s0_exc_i,
   input  logic [7:0]  s1_exc_i,
   input  logic        s0_is_store_i,
   input  logic        s1_is_store_i,
   input  logic [31:0] s0_badaddr_i,
   input  logic [31:0] s1_badaddr_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] exc_pc_o,
   output logic [31:0] exc_badaddr_o,
   output logic        exc_ds_o,
   output logic        flush_o,
   output logic        redirect_o,
   output logic [31:0] new_pc_o,
   output logic        busy_o,
   output logic [31:0] exc_count_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_e;

   // bad_sel: 0 = no bad address, 1 = slot pc, 2 = slot data address
   typedef struct packed {
      logic       hit;
      logic [4:0] code;
      logic [1:0] bad_sel;
   } pick_t;

   function automatic pick_t pick(input logic valid, input logic intr,
                                  input logic [7:0] exc, input logic store);
      pick_t p;
      p = '0;
      if (!valid)      p = '0;
      else if (intr)   p = '{1'b1, 5'h01, 2'd0};
      else if (exc[0]) p = '{1'b1, 5'h04, 2'd1};
      else if (exc[1]) p = '{1'b1, 5'h0a, 2'd0};
      else if (exc[2]) p = '{1'b1, 5'h08, 2'd0};
      else if (exc[3]) p = '{1'b1, 5'h09, 2'd0};
      else if (exc[4]) p = '{1'b1, 5'h0d, 2'd0};
      else if (exc[5]) p = '{1'b1, 5'h0c, 2'd0};
      else if (exc[6]) p = '{1'b1, (store ? 5'h05 : 5'h04), 2'd2};
      else if (exc[7]) p = '{1'b1, 5'h0e, 2'd0};
      else             p = '0;
      return p;
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  hold_code_q, hold_code_d;
   logic [31:0] hold_pc_q, hold_pc_d, hold_bad_q, hold_bad_d, hold_epc_q, hold_epc_d;
   logic        hold_ds_q, hold_ds_d;
   logic [31:0] type_q, pc_q, bad_q, new_pc_q;
   logic        ds_q, flush_q, redirect_q;

   logic        int_pend_s, win_hit_s, win_ds_s, commit_s, c_ds_s;
   logic [4:0]  win_code_s, c_code_s;
   logic [31:0] win_pc_s, win_bad_s, c_pc_s, c_bad_s, c_epc_s;
   pick_t       p0_s, p1_s, pw_s;
   logic        unused_s;

   assign unused_s   = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
   assign int_pend_s = (|(status_i[15:8] & cause_i[15:8])) & status_i[0] & ~status_i[1];

   // Winner selection: slot 0 first, slot 1 only when slot 0 has no event
   always_comb begin
      p0_s = pick(s0_valid_i, int_pend_s, s0_exc_i, s0_is_store_i);
      p1_s = pick(s1_valid_i, 1'b0, s1_exc_i, s1_is_store_i);
      if (p0_s.hit) begin
         pw_s     = p0_s;
         win_pc_s = s0_pc_i;
         win_ds_s = s0_ds_i;
         win_bad_s = (p0_s.bad_sel == 2'd1) ? s0_pc_i :
                     (p0_s.bad_sel == 2'd2) ? s0_badaddr_i : 32'd0;
      end else begin
         pw_s     = p1_s;
         win_pc_s = s1_pc_i;
         win_ds_s = s1_ds_i;
         win_bad_s = (p1_s.bad_sel == 2'd1) ? s1_pc_i :
                     (p1_s.bad_sel == 2'd2) ? s1_badaddr_i : 32'd0;
      end
      win_hit_s  = pw_s.hit;
      win_code_s = pw_s.code;
   end

   // Next-state and commit selection
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_code_d = hold_code_q;
      hold_pc_d   = hold_pc_q;
      hold_bad_d  = hold_bad_q;
      hold_epc_d  = hold_epc_q;
      hold_ds_d   = hold_ds_q;
      commit_s    = 1'b0;
      c_code_s    = win_code_s;
      c_pc_s      = win_pc_s;
      c_bad_s     = win_bad_s;
      c_ds_s      = win_ds_s;
      c_epc_s     = epc_i;
      case (state_q)
         IDLE: begin
            if (win_hit_s && mem_stall_i) begin
               hold_code_d = win_code_s;
               hold_pc_d   = win_pc_s;
               hold_bad_d  = win_bad_s;
               hold_ds_d   = win_ds_s;
               hold_epc_d  = epc_i;
               state_d     = HOLD;
            end else if (win_hit_s) begin
               commit_s = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            c_code_s = hold_code_q;
            c_pc_s   = hold_pc_q;
            c_bad_s  = hold_bad_q;
            c_ds_s   = hold_ds_q;
            c_epc_s  = hold_epc_q;
            if (!mem_stall_i) commit_s = 1'b1;
            else              state_d  = HOLD;
         end
         FLUSH: begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      if (commit_s) begin
         state_d = FLUSH;
         cnt_d   = 4'(FLUSH_CYCLES - 32'd1);
      end else begin
         cnt_d = cnt_d;
      end
   end

   // State, hold registers and registered CP0/flush outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         hold_code_q <= 5'd0;
         hold_pc_q   <= 32'd0;
         hold_bad_q  <= 32'd0;
         hold_epc_q  <= 32'd0;
         hold_ds_q   <= 1'b0;
         type_q      <= 32'd0;
         pc_q        <= 32'd0;
         bad_q       <= 32'd0;
         ds_q        <= 1'b0;
         flush_q     <= 1'b0;
         redirect_q  <= 1'b0;
         new_pc_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_code_q <= hold_code_d;
         hold_pc_q   <= hold_pc_d;
         hold_bad_q  <= hold_bad_d;
         hold_epc_q  <= hold_epc_d;
         hold_ds_q   <= hold_ds_d;
         flush_q     <= (state_d == FLUSH);
         redirect_q  <= commit_s;
         if (commit_s) begin
            type_q   <= {27'd0, c_code_s};
            pc_q     <= c_pc_s;
            bad_q    <= c_bad_s;
            ds_q     <= c_ds_s;
            new_pc_q <= (c_code_s == 5'h0e) ? c_epc_s : EXC_VECTOR;
         end else begin
            type_q   <= 32'd0;
            pc_q     <= 32'd0;
            bad_q    <= 32'd0;
            ds_q     <= 1'b0;
            new_pc_q <= new_pc_q;
         end
      end
   end

`ifdef EXCEPT_SCHED_PERF_EN
   logic [31:0] count_q;

   // Counts committed exceptions/interrupts, ERET excluded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                   count_q <= 32'd0;
      else if (commit_s && (c_code_s != 5'h0e))   count_q <= count_q + 32'd1;
      else                                        count_q <= count_q;
   end

   assign exc_count_o = count_q;
`else
   assign exc_count_o = 32'd0;
`endif

   assign excepttype_o  = type_q;
   assign exc_pc_o      = pc_q;
   assign exc_badaddr_o = bad_q;
   assign exc_ds_o      = ds_q;
   assign flush_o       = flush_q;
   assign redirect_o    = redirect_q;
   assign new_pc_o      = new_pc_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_except_sched.sv
// Randomized self-checking bench for except_sched against an event-level reference model.
module tb_except_sched;
   localparam logic [31:0] VEC = 32'hBFC00380;
   localparam int          FC  = 2;
   localparam logic [31:0] CODE_TBL [8] = '{32'h4, 32'ha, 32'h8, 32'h9, 32'hd, 32'hc, 32'h4, 32'he};

   logic        clk = 1'b0, rst = 1'b0;
   logic        mem_stall_i, s0_valid_i, s1_valid_i, s0_ds_i, s1_ds_i, s0_is_store_i, s1_is_store_i;
   logic [31:0] s0_pc_i, s1_pc_i, s0_badaddr_i, s1_badaddr_i, status_i, cause_i, epc_i;
   logic [7:0]  s0_exc_i, s1_exc_i;
   logic [31:0] excepttype_o, exc_pc_o, exc_badaddr_o, new_pc_o, exc_count_o;
   logic        exc_ds_o, flush_o, redirect_o, busy_o;

   int n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   except_sched #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .mem_stall_i(mem_stall_i),
      .s0_valid_i(s0_valid_i), .s1_valid_i(s1_valid_i),
      .s0_pc_i(s0_pc_i), .s1_pc_i(s1_pc_i), .s0_ds_i(s0_ds_i), .s1_ds_i(s1_ds_i),
      .s0_exc_i(s0_exc_i), .s1_exc_i(s1_exc_i),
      .s0_is_store_i(s0_is_store_i), .s1_is_store_i(s1_is_store_i),
      .s0_badaddr_i(s0_badaddr_i), .s1_badaddr_i(s1_badaddr_i),
      .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
      .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o), .exc_badaddr_o(exc_badaddr_o),
      .exc_ds_o(exc_ds_o), .flush_o(flush_o), .redirect_o(redirect_o),
      .new_pc_o(new_pc_o), .busy_o(busy_o), .exc_count_o(exc_count_o)
   );

   typedef struct {
      bit          hit;
      logic [31:0] code, pc, bad, epc;
      bit          ds;
   } ev_t;

   // Reference model state: an event waiting out a stall, and flush cycles still owed
   ev_t         m_pend, m_c, m_w;
   int          m_flush_left = 0;
   logic [31:0] m_type = 32'd0, m_pc = 32'd0, m_bad = 32'd0, m_newpc = 32'd0, m_count = 32'd0;
   bit          m_ds = 1'b0, m_redirect = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic ev_t slot_ev(input bit valid, input bit intr, input logic [7:0] exc,
                                   input bit store, input logic [31:0] pc, input logic [31:0] bad,
                                   input bit ds, input logic [31:0] epc);
      ev_t e;
      e.hit = 1'b0; e.code = 32'd0; e.pc = pc; e.bad = 32'd0; e.ds = ds; e.epc = epc;
      if (valid && intr) begin
         e.hit = 1'b1; e.code = 32'd1;
      end else if (valid) begin
         // Flag bit order equals priority order: scan from lowest priority so the highest wins
         for (int i = 7; i >= 0; i--) begin
            if (exc[i]) begin
               e.hit  = 1'b1;
               e.code = (i == 6 && store) ? 32'h5 : CODE_TBL[i];
               e.bad  = (i == 0) ? pc : (i == 6) ? bad : 32'd0;
            end
         end
      end
      return e;
   endfunction

   function automatic ev_t winner();
      ev_t e0;
      bit  ip;
      ip = ((status_i[15:8] & cause_i[15:8]) != 8'd0) && status_i[0] && !status_i[1];
      e0 = slot_ev(s0_valid_i, ip, s0_exc_i, s0_is_store_i, s0_pc_i, s0_badaddr_i, s0_ds_i, epc_i);
      if (e0.hit) return e0;
      return slot_ev(s1_valid_i, 1'b0, s1_exc_i, s1_is_store_i, s1_pc_i, s1_badaddr_i, s1_ds_i, epc_i);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_flush_left = 0; m_pend.hit = 1'b0;
         m_type = 32'd0; m_pc = 32'd0; m_bad = 32'd0; m_ds = 1'b0;
         m_redirect = 1'b0; m_newpc = 32'd0; m_count = 32'd0;
      end else begin
         m_c.hit = 1'b0;
         if (m_flush_left > 0) begin
            m_flush_left--;
         end else if (m_pend.hit) begin
            if (!mem_stall_i) begin m_c = m_pend; m_pend.hit = 1'b0; end
         end else begin
            m_w = winner();
            if (m_w.hit && mem_stall_i) m_pend = m_w;
            else if (m_w.hit)           m_c = m_w;
         end
         m_redirect = m_c.hit;
         m_type = m_c.hit ? m_c.code : 32'd0;
         m_pc   = m_c.hit ? m_c.pc   : 32'd0;
         m_bad  = m_c.hit ? m_c.bad  : 32'd0;
         m_ds   = m_c.hit ? m_c.ds   : 1'b0;
         if (m_c.hit) begin
            m_flush_left = FC;
            m_newpc = (m_c.code == 32'he) ? m_c.epc : VEC;
`ifdef EXCEPT_SCHED_PERF_EN
            if (m_c.code != 32'he) m_count = m_count + 32'd1;
`endif
         end
      end
   end

   always @(negedge clk) begin
      chk("excepttype", excepttype_o, m_type);
      chk("exc_pc", exc_pc_o, m_pc);
      chk("exc_badaddr", exc_badaddr_o, m_bad);
      chk("exc_ds", exc_ds_o, m_ds);
      chk("redirect", redirect_o, m_redirect);
      chk("new_pc", new_pc_o, m_newpc);
      chk("flush", flush_o, m_flush_left > 0);
      chk("busy", busy_o, (m_flush_left > 0) || m_pend.hit);
      chk("exc_count", exc_count_o, m_count);
   end

   task automatic idle_inputs();
      mem_stall_i = 1'b0; s0_valid_i = 1'b0; s1_valid_i = 1'b0;
      s0_pc_i = 32'd0; s1_pc_i = 32'd0; s0_ds_i = 1'b0; s1_ds_i = 1'b0;
      s0_exc_i = 8'd0; s1_exc_i = 8'd0; s0_is_store_i = 1'b0; s1_is_store_i = 1'b0;
      s0_badaddr_i = 32'd0; s1_badaddr_i = 32'd0;
      status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0;
   endtask

   function automatic logic [7:0] rnd_flags();
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      return 8'd0;
      else if (r < 9) return 8'(1 << $urandom_range(0, 7));
      else            return 8'($urandom);
   endfunction

   logic [31:0] cnt_before;

   initial begin
      idle_inputs();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_type", excepttype_o, 32'd0);
      chk("rst_flush", flush_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_newpc", new_pc_o, 32'd0);
      chk("rst_count", exc_count_o, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Syscall, no stall
      s0_valid_i = 1'b1; s0_pc_i = 32'hBFC00100; s0_exc_i = 8'h04;
      @(negedge clk);
      chk("sys_type", excepttype_o, 32'h8);
      chk("sys_model", m_type, 32'h8);
      chk("sys_pc", exc_pc_o, 32'hBFC00100);
      chk("sys_redirect", redirect_o, 1'b1);
      chk("sys_newpc", new_pc_o, 32'hBFC00380);
      chk("sys_flush1", flush_o, 1'b1);
      idle_inputs();
      @(negedge clk);
      chk("sys_flush2", flush_o, 1'b1);
      chk("sys_type_gone", excepttype_o, 32'd0);
      chk("sys_redirect_gone", redirect_o, 1'b0);
      @(negedge clk);
      chk("sys_flush_end", flush_o, 1'b0);
      chk("sys_busy_end", busy_o, 1'b0);

      // RI in slot 0 beats Ov in slot 1
      s0_valid_i = 1'b1; s0_pc_i = 32'h00000100; s0_exc_i = 8'h02;
      s1_valid_i = 1'b1; s1_pc_i = 32'h00000104; s1_exc_i = 8'h20;
      @(negedge clk);
      chk("ri_type", excepttype_o, 32'ha);
      chk("ri_pc", exc_pc_o, 32'h00000100);
      idle_inputs();
      repeat (2) @(negedge clk);

      // Interrupt beats Ov; masked by EXL
      s0_valid_i = 1'b1; s0_pc_i = 32'h00000200; s0_exc_i = 8'h20;
      status_i = 32'h0000FF01; cause_i = 32'h00000400;
      @(negedge clk);
      chk("int_type", excepttype_o, 32'h1);
      chk("int_model", m_type, 32'h1);
      idle_inputs();
      repeat (2) @(negedge clk);
      s0_valid_i = 1'b1; s0_pc_i = 32'h00000200; s0_exc_i = 8'h20;
      status_i = 32'h0000FF03; cause_i = 32'h00000400;
      @(negedge clk);
      chk("exl_type", excepttype_o, 32'hc);
      idle_inputs();
      repeat (2) @(negedge clk);

      // Slot 1 store fault held across a 3-cycle stall
      s0_valid_i = 1'b1; s1_valid_i = 1'b1; s1_pc_i = 32'h00000300; s1_exc_i = 8'h40;
      s1_is_store_i = 1'b1; s1_badaddr_i = 32'h80001003; mem_stall_i = 1'b1;
      @(negedge clk);
      chk("hold_busy1", busy_o, 1'b1);
      chk("hold_redirect1", redirect_o, 1'b0);
      idle_inputs(); mem_stall_i = 1'b1;
      @(negedge clk);
      chk("hold_busy2", busy_o, 1'b1);
      chk("hold_type2", excepttype_o, 32'd0);
      @(negedge clk);
      chk("hold_busy3", busy_o, 1'b1);
      mem_stall_i = 1'b0;
      @(negedge clk);
      chk("ades_type", excepttype_o, 32'h5);
      chk("ades_bad", exc_badaddr_o, 32'h80001003);
      chk("ades_pc", exc_pc_o, 32'h00000300);
      repeat (2) @(negedge clk);

      // ERET returns to EPC and is not counted
      cnt_before = m_count;
      s0_valid_i = 1'b1; s0_pc_i = 32'h00000400; s0_exc_i = 8'h80; epc_i = 32'hBFC00200;
      @(negedge clk);
      chk("eret_type", excepttype_o, 32'he);
      chk("eret_newpc", new_pc_o, 32'hBFC00200);
      chk("eret_count", exc_count_o, cnt_before);
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("newpc_holds", new_pc_o, 32'hBFC00200);

      // Reset during the second flush cycle
      s0_valid_i = 1'b1; s0_pc_i = 32'h00000500; s0_exc_i = 8'h04;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      chk("pre_rst_flush", flush_o, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_flush", flush_o, 1'b0);
      chk("rst_mid_busy", busy_o, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_redirect", redirect_o, 1'b0);
      chk("post_rst_type", excepttype_o, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         mem_stall_i   = ($urandom_range(0, 3) == 0);
         s0_valid_i    = ($urandom_range(0, 3) != 0);
         s1_valid_i    = ($urandom_range(0, 3) != 0);
         s0_pc_i       = {$urandom} & 32'hFFFF_FFFC;
         s1_pc_i       = s0_pc_i + 32'd4;
         s0_ds_i       = 1'($urandom);
         s1_ds_i       = 1'($urandom);
         s0_exc_i      = rnd_flags();
         s1_exc_i      = rnd_flags();
         s0_is_store_i = 1'($urandom);
         s1_is_store_i = 1'($urandom);
         s0_badaddr_i  = $urandom;
         s1_badaddr_i  = $urandom;
         epc_i         = $urandom;
         case ($urandom_range(0, 3))
            0:       status_i = 32'd0;
            1:       status_i = 32'h0000FF01;
            2:       status_i = 32'h0000FF03;
            default: status_i = $urandom;
         endcase
         cause_i = ($urandom_range(0, 1) == 0) ? 32'h00000400 : $urandom;
         @(negedge clk);
      end
      idle_inputs();
      repeat (6) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/except_sched.md
Name: except_sched

Overview:
- Exception/interrupt scheduler for the dual-issue MIPS core.
- Collects per-slot exception flags from the memory stage, plus the interrupt-pending condition from CP0 status/cause.
- Picks the single winning event and drives the CP0 register file's exception inputs (excepttype, instruction address, bad address, delay-slot flag) as a one-cycle commit pulse.
- Sequences the pipeline flush and PC redirect, and holds a pending exception across memory stalls.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- FLUSH_CYCLES, 2, cycles flush_o stays high per event (1..15).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- mem_stall_i  input  1  memory stage stalled; no commit allowed
- s0_valid_i / s1_valid_i  input  1  slot 0 / slot 1 holds a real instruction
- s0_pc_i / s1_pc_i  input  32  slot PC
- s0_ds_i / s1_ds_i  input  1  slot is in a delay slot
- s0_exc_i / s1_exc_i  input  8  flags: [0]AdEL-fetch [1]RI [2]Syscall [3]Break [4]Trap [5]Ov [6]AdEL/AdES-data [7]ERET
- s0_is_store_i / s1_is_store_i  input  1  data fault is a store (selects AdES)
- s0_badaddr_i / s1_badaddr_i  input  32  data address of the slot
- status_i, cause_i, epc_i  input  32  current CP0 values
- excepttype_o  output  32  to CP0: code, or 0
- exc_pc_o  output  32  to CP0 current_inst_addr
- exc_badaddr_o  output  32  to CP0 bad_addr
- exc_ds_o  output  1  to CP0 is_in_delayslot
- flush_o  output  1  flush IF..MEM
- redirect_o  output  1  one-cycle PC redirect strobe
- new_pc_o  output  32  redirect target
- busy_o  output  1  FSM not in IDLE
- exc_count_o  output  32  see Optional Feature

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0. Reset asserted mid-HOLD or mid-FLUSH aborts to IDLE immediately.
- int_pend = (|(status_i[15:8] & cause_i[15:8])) & status_i[0] & ~status_i[1]. An interrupt is taken only on s0_valid_i.
- Priority:
  - Slot 0 is considered first. Slot 1 is considered only if slot 0 has no event and s1_valid_i.
  - Within a slot: INT(0x1, slot 0 only) > AdEL-fetch(0x4, badaddr = pc) > RI(0xa) > Syscall(0x8) > Break(0x9) > Trap(0xd) > Ov(0xc) > data fault(0x5 if is_store else 0x4, badaddr = s*_badaddr_i) > ERET(0xe).
  - Invalid slots are ignored.
- FSM IDLE:
  - Winner found, mem_stall_i = 0: register the winner and go to FLUSH.
  - Winner found, mem_stall_i = 1: latch the winner (code, pc, ds, badaddr, epc_i snapshot) into hold registers and go to HOLD. Incoming flags are ignored while in HOLD.
- FSM HOLD: stays until mem_stall_i = 0, then commits the latched winner and goes to FLUSH.
- Commit (first cycle of FLUSH, i.e. T+1 after detection with no stall):
  - excepttype_o, exc_pc_o, exc_badaddr_o, exc_ds_o are valid for exactly this cycle; 0 otherwise.
  - redirect_o = 1 for this cycle. new_pc_o = epc snapshot for ERET, else EXC_VECTOR.
  - new_pc_o holds its value until the next commit.
- FSM FLUSH:
  - flush_o = 1 for FLUSH_CYCLES consecutive cycles, counted by a 4-bit down-counter, then return to IDLE.
  - New flags are ignored during FLUSH; a back-to-back event is first seen in the IDLE cycle.
- exc_pc_o = slot PC. exc_ds_o = slot ds flag. CP0 applies the -4 adjustment for delay-slot instructions.
- busy_o = (state != IDLE).

Optional Feature:
- Macro EXCEPT_SCHED_PERF_EN.
- Defined: exc_count_o is a 32-bit counter that increments on each commit whose code != 0xe, wraps at 2^32, and is cleared by reset.
- Undefined: exc_count_o is tied to 0 and no counter logic is built.

Test Plan:
- Slot 0 Syscall at pc 0xBFC00100, no stall -> next cycle excepttype_o = 0x8, exc_pc_o = 0xBFC00100, redirect_o = 1, new_pc_o = 0xBFC00380; flush_o high exactly 2 cycles.
- Slot 0 RI plus slot 1 Ov in the same cycle -> code 0xa, slot 0 pc; slot 1 event discarded.
- status = 0x0000FF01, cause = 0x00000400, s0_valid = 1, s0_exc = Ov -> code 0x1 (INT beats Ov); with status[1] = 1 -> code 0xc.
- Slot 1 store fault, badaddr 0x80001003, mem_stall_i high 3 cycles -> no commit while stalled, busy_o = 1; then code 0x5, exc_badaddr_o = 0x80001003 in the cycle after the stall drops.
- ERET, epc_i = 0xBFC00200 -> code 0xe, new_pc_o = 0xBFC00200; exc_count_o unchanged (PERF_EN defined).
- Reset pulsed low during the second FLUSH cycle -> flush_o = 0 and busy_o = 0 immediately; no commit after release.
